// File: rtl/bcd2binary.sv
// bcd2binary: packed BCD to unsigned binary converter using iterative reverse double-dabble.
// Define BCD_CHECK_EN to flag invalid digits on o_error and force a zero result.
module bcd2binary #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int BINARY_WIDTH   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_busy_input,
    input  logic                        i_empty_input,
    input  logic                        i_busy_output,
    input  logic                        i_full_output,
    output logic [BINARY_WIDTH-1:0]     o_binary,
    output logic                        o_valid_output,
    output logic                        o_req_input,
    output logic                        o_error
);
    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int LW = $clog2(BINARY_WIDTH + 1);
    localparam int DW = DECIMAL_DIGITS > 1 ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [LW-1:0] LAST_SHIFT = LW'(BINARY_WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DECIMAL_DIGITS - 1);

    generate
        if (BINARY_WIDTH < $clog2(10 ** DECIMAL_DIGITS)) begin : g_width_check
            $error("bcd2binary: BINARY_WIDTH too small for DECIMAL_DIGITS");
        end
    endgenerate

    typedef enum logic [2:0] {
        s_IDLE, s_SEND_REQ, s_GET_DATA, s_SHIFT, s_ADJUST, s_DONE, s_VALID
    } state_t;

    state_t state, state_next;
    logic [BCD_W-1:0] bcd_reg;
    logic [BINARY_WIDTH-1:0] bin_reg;
    logic [LW-1:0] loop_count;
    logic [DW-1:0] digit_index;
    logic [BCD_W+BINARY_WIDTH-1:0] shifted;
    logic [3:0] digit;
    logic bcd_bad;

    assign shifted = {bcd_reg, bin_reg} >> 1;
    assign digit = bcd_reg[{digit_index, 2'b00} +: 4];

`ifdef BCD_CHECK_EN
    always_comb begin
        bcd_bad = 1'b0;
        for (int k = 0; k < DECIMAL_DIGITS; k++)
            bcd_bad = bcd_bad | (i_BCD[4*k +: 4] > 4'd9);
    end
`else
    assign bcd_bad = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= s_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = s_IDLE;
        o_req_input = state == s_SEND_REQ;
        o_valid_output = state == s_VALID;
        case (state)
            s_IDLE:     state_next = (!i_busy_input && !i_empty_input) ? s_SEND_REQ : s_IDLE;
            s_SEND_REQ: state_next = s_GET_DATA;
            s_GET_DATA: state_next = bcd_bad ? s_DONE : s_SHIFT;
            s_SHIFT:    state_next = (loop_count == LAST_SHIFT) ? s_DONE : s_ADJUST;
            s_ADJUST:   state_next = (digit_index == LAST_DIGIT) ? s_SHIFT : s_ADJUST;
            s_DONE:     state_next = (i_full_output || i_busy_output) ? s_DONE : s_VALID;
            s_VALID:    state_next = s_IDLE;
            default:    state_next = s_IDLE;
        endcase
    end

    // o_binary is loaded only on the transition into s_DONE so it stays stable mid-conversion
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bcd_reg     <= '0;
            bin_reg     <= '0;
            loop_count  <= '0;
            digit_index <= '0;
            o_binary    <= '0;
            o_error     <= 1'b0;
        end else begin
            case (state)
                s_GET_DATA: begin
                    bcd_reg     <= i_BCD;
                    bin_reg     <= '0;
                    loop_count  <= '0;
                    digit_index <= '0;
                    o_error     <= bcd_bad;
                    if (bcd_bad)
                        o_binary <= '0;
                end
                s_SHIFT: begin
                    {bcd_reg, bin_reg} <= shifted;
                    if (loop_count == LAST_SHIFT) begin
                        loop_count <= '0;
                        o_binary   <= shifted[BINARY_WIDTH-1:0];
                    end else begin
                        loop_count <= loop_count + 1'b1;
                    end
                end
                s_ADJUST: begin
                    if (digit >= 4'd8)
                        bcd_reg[{digit_index, 2'b00} +: 4] <= digit - 4'd3;
                    digit_index <= (digit_index == LAST_DIGIT) ? '0 : digit_index + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bcd2binary.md
Name: bcd2binary

Overview:
- Converts a DECIMAL_DIGITS-digit packed BCD word into an unsigned binary value using iterative reverse double-dabble: shift right, then subtract 3 from any BCD digit >= 8.
- Sits between an input FIFO/handshake module and an output FIFO/handshake module. Uses the same request/valid protocol as the task-5 binary-to-BCD converter, so the two can run back-to-back for loopback testing.

Parameters:
- DECIMAL_DIGITS, 2, number of packed BCD digits on i_BCD.
- BINARY_WIDTH, 8, output width; must be >= ceil(log2(10^DECIMAL_DIGITS)), elaboration error otherwise.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_BCD  input  DECIMAL_DIGITS*4  packed BCD operand; digit 0 in bits [3:0].
- i_busy_input  input  1  upstream module busy.
- i_empty_input  input  1  upstream FIFO empty.
- i_busy_output  input  1  downstream module busy.
- i_full_output  input  1  downstream FIFO full.
- o_binary  output  BINARY_WIDTH  conversion result.
- o_valid_output  output  1  one-cycle strobe; o_binary is valid.
- o_req_input  output  1  one-cycle read request to upstream.
- o_error  output  1  invalid BCD digit detected (BCD_CHECK_EN only; tied 0 otherwise).

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state s_IDLE; o_binary 0; o_valid_output 0; o_req_input 0; o_error 0. All internal counters and shift registers are 0.
- Working register: {bcd_reg (DECIMAL_DIGITS*4), bin_reg (BINARY_WIDTH)}; loop_count counts shifts, digit_index selects the digit being adjusted.
- FSM states: s_IDLE, s_SEND_REQ, s_GET_DATA, s_SHIFT, s_ADJUST, s_DONE, s_VALID. Every transition is a single registered step.
- s_IDLE: go to s_SEND_REQ when !i_busy_input && !i_empty_input; otherwise stay.
- s_SEND_REQ: o_req_input = 1 for exactly this cycle (state decode). Go to s_GET_DATA.
- s_GET_DATA: latch i_BCD into bcd_reg; clear bin_reg, loop_count and digit_index; clear o_error. Go to s_SHIFT.
- s_SHIFT: shift {bcd_reg, bin_reg} right by 1 (bcd_reg LSB enters bin_reg MSB). If loop_count == BINARY_WIDTH-1, clear loop_count and go to s_DONE; else increment loop_count and go to s_ADJUST.
- s_ADJUST: one digit per cycle. If digit[digit_index] >= 8, subtract 3 (4-bit, no carry into the neighbouring digit). If digit_index == DECIMAL_DIGITS-1, clear it and go to s_SHIFT; else increment it and stay.
- Latency from the s_GET_DATA cycle to entering s_DONE: BINARY_WIDTH + (BINARY_WIDTH-1)*DECIMAL_DIGITS cycles (22 for the defaults).
- s_DONE: o_binary <= bin_reg on entry. Stay while i_full_output || i_busy_output; otherwise go to s_VALID.
- s_VALID: o_valid_output = 1 for exactly this cycle. Go to s_IDLE.
- o_binary holds its value until the next s_DONE entry; it never changes during a conversion.
- Backpressure: only s_IDLE (input side) and s_DONE (output side) wait. Handshake inputs are ignored in all other states.
- Simultaneous input-ready and output-blocked: impossible, because a new request is issued only from s_IDLE.
- Reset mid-conversion: abort immediately to the reset values. The partially consumed input word is lost; no o_valid_output is issued.
- Illegal state encoding: recover to s_IDLE on the next clock.

Optional Feature:
- Macro: BCD_CHECK_EN.
- With BCD_CHECK_EN:
  - In s_GET_DATA, any i_BCD digit > 9 sets o_error (registered; visible from the next cycle).
  - The FSM then skips the conversion and goes directly to s_DONE with bin_reg = 0, so o_binary = 0.
  - o_error stays asserted through s_VALID and clears at the next s_GET_DATA.
- Without BCD_CHECK_EN: o_error is tied 0, and invalid digits are converted arithmetically with no detection. Logic and latency are otherwise identical.

Test Plan:
- Basic max value: i_BCD=0x99, FIFOs ready -> o_req_input pulse one cycle after the IDLE condition; o_binary=0x63; o_valid_output one pulse exactly 24 cycles after the s_GET_DATA cycle (22 + s_DONE + s_VALID).
- Zero and mid value: i_BCD=0x00 -> o_binary=0x00; then i_BCD=0x42 -> o_binary=0x2A. Two clean valid pulses, no spurious o_req_input between them.
- Input gating: i_empty_input=1 or i_busy_input=1 held for 10 cycles -> no o_req_input; req appears one cycle after both deassert.
- Output backpressure: i_BCD=0x37, i_full_output=1 for 5 cycles after s_DONE -> o_valid_output delayed until the cycle after release; o_binary=0x25 held stable throughout the wait.
- Reset mid-operation: assert i_rst asynchronously during s_ADJUST of the 4th shift -> all outputs 0 immediately, no valid pulse; the next conversion of 0x15 gives 0x0F correctly.
- BCD_CHECK_EN defined: i_BCD=0x1F -> o_error=1, o_binary=0x00, valid pulse. Without the macro: o_error stays 0 and a valid pulse is still produced.
